mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the mux16 16:1 multiplexer.
- On a start request it steps the mux select across all 16 channels and waits a programmable settle time on each enabled channel.
- It samples the mux output Y per channel and assembles a 16-bit result word. Done/valid handshake to the consumer.
- Sits between control logic and mux16: drives mux16.sel, reads mux16.Y.

Parameters:
NCH, 16, number of mux channels scanned; fixed at 16 for mux16
SELW, 4, select width; log2(NCH)
SETTLE, 1, settle cycles between driving sel and sampling an enabled channel; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  scan request; sampled only in IDLE
chan_mask  input  16  per-channel enable; latched when start is accepted
sel  output  4  binary channel select to mux16.sel
mux_y  input  1  mux16.Y
busy  output  1  high while scanning
done  output  1  one-cycle pulse when scan completes
valid  output  1  data holds a complete scan result
data  output  16  scan result; bit i = sampled mux_y for channel i, 0 if channel i masked

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=0, busy=0, done=0, valid=0, data=16'h0000, channel counter=0, settle counter=0, latched mask=0. Reset mid-scan aborts immediately. No partial result is kept.
- States: IDLE, SETTLE, SAMPLE, SKIP, DONE.
- IDLE:
  - sel=0, busy=0.
  - start=1 at a rising edge: latch chan_mask, ch=0, clear valid, clear data.
  - Next state: if chan_mask==0, go to DONE; else SETTLE if mask[0] else SKIP.
- SETTLE:
  - sel=ch, busy=1.
  - Lasts exactly SETTLE cycles (down-counter), then SAMPLE.
- SAMPLE:
  - sel=ch, busy=1, one cycle.
  - At its closing edge: data[ch]<=mux_y.
  - Then advance.
- SKIP:
  - sel=ch, busy=1, one cycle.
  - data[ch] stays 0.
  - Then advance.
- Advance:
  - if ch==15, go to DONE.
  - else ch<=ch+1, then SETTLE if mask[ch+1] else SKIP.
  - No wrap past channel 15.
- DONE: one cycle, done=1, busy=0, valid<=1, sel=0. Then IDLE.
- valid stays 1 and data stays stable until the next accepted start or reset.
- Latency, from the start-sampling edge to the first cycle with done=1:
  - 1 + E*(SETTLE+1) + (16-E) cycles, where E = number of set mask bits.
  - mask=0 gives done in the cycle after start.
- start while busy or in DONE: ignored, with no queuing. start held high continuously re-triggers a scan from each IDLE visit.
- chan_mask changes during a scan have no effect; only the latched copy is used.
- sel changes only on clk edges and is glitch-free registered. It is held constant for the full SETTLE+SAMPLE window of a channel.
- mux_y is sampled only in SAMPLE; its value in any other state is don't-care.

Test Plan:
1. rst pulse mid-scan (after 10 busy cycles, mask=16'hFFFF) -> next cycle busy=0, sel=0, data=16'h0000, valid=0, done=0. No done pulse follows.
2. mux16 data X=16'h1234, mask=16'hFFFF, SETTLE=1, start pulse:
   - sel walks 0..15, each value held 2 cycles.
   - busy high 32 cycles.
   - done pulse 33 cycles after the start edge.
   - data=16'h1234, valid=1.
3. X=16'hFFFF, mask=16'h00FF, SETTLE=1:
   - busy 8*2+8*1=24 cycles.
   - data=16'h00FF.
   - sel values 8..15 each held 1 cycle.
4. mask=16'h0000, start -> done in the next cycle, busy never high, data=16'h0000, valid=1.
5. SETTLE=3, mask=16'h8001, X=16'h8001 -> busy 4+14+4=22 cycles, data=16'h8001. start pulses during busy are ignored, giving exactly one done.
6. X changed to 16'hA5A5 after scan 1 of X=16'h1234 completes, no new start -> data stays 16'h1234. A new start clears valid, and the next done gives data=16'hA5A5.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side bus between the scan sequencer, its consumer and mux16.
// master: control side (start/mask) plus mux16 feeding mux_y; slave: the sequencer.
interface mux_scan_ctrl_if #(
    parameter int NCH  = 16,
    parameter int SELW = 4
);
    logic            start;
    logic [NCH-1:0]  chan_mask;
    logic [SELW-1:0] sel;
    logic            mux_y;
    logic            busy;
    logic            done;
    logic            valid;
    logic [NCH-1:0]  data;

    modport master (
        output start, chan_mask, mux_y,
        input  sel, busy, done, valid, data
    );

    modport slave (
        input  start, chan_mask, mux_y,
        output sel, busy, done, valid, data
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for mux16: walks sel over all channels, waits SETTLE cycles on
// each enabled channel, samples mux_y into a result word and raises done/valid.
module mux_scan_ctrl #(
    parameter int NCH    = 16,
    parameter int SELW   = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_SKIP,
        S_DONE
    } state_e;

    // Settle counter is loaded with SETTLE-1 so the SETTLE state lasts exactly SETTLE cycles.
    localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

    state_e          state_q;
    logic [SELW-1:0] ch_q;
    logic [SELW-1:0] sel_q;
    logic [3:0]      cnt_q;
    logic [NCH-1:0]  mask_q;
    logic [NCH-1:0]  data_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;

    logic [SELW-1:0] ch_d;
    logic            next_en_d;

    // Next channel index and whether it is enabled in the latched mask.
    always_comb begin
        ch_d      = ch_q + SELW'(1);
        next_en_d = mask_q[ch_d];
    end

    // Sequencer FSM with all outputs registered so sel never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mask_q <= bus.chan_mask;
                        ch_q   <= '0;
                        sel_q  <= '0;
                        cnt_q  <= CNT_LOAD;
                        data_q <= '0;
                        if (bus.chan_mask == '0) begin
                            // Nothing to scan: report an all-zero result right away.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= bus.chan_mask[0] ? S_SETTLE : S_SKIP;
                        end
                    end
                end

                S_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                S_SAMPLE, S_SKIP: begin
                    if (state_q == S_SAMPLE) begin
                        data_q[ch_q] <= bus.mux_y;
                    end
                    if (ch_q == CH_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        sel_q   <= '0;
                    end else begin
                        ch_q    <= ch_d;
                        sel_q   <= ch_d;
                        cnt_q   <= CNT_LOAD;
                        state_q <= next_en_d ? S_SETTLE : S_SKIP;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    sel_q   <= '0;
                end
            endcase
        end
    end

    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.data  = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) driven in
// lockstep, with a mux16 model and a channel-list reference of each scan.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mask = 16'h0000;
    logic [15:0] xval = 16'h0000;

    int ncmp  = 0;
    int nfail = 0;

    mux_scan_ctrl_if ifc1 ();
    mux_scan_ctrl_if ifc3 ();

    assign ifc1.start     = start;
    assign ifc3.start     = start;
    assign ifc1.chan_mask = mask;
    assign ifc3.chan_mask = mask;
    assign ifc1.mux_y     = xval[ifc1.sel];
    assign ifc3.mux_y     = xval[ifc3.sel];

    mux_scan_ctrl #(.NCH(16), .SELW(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
    mux_scan_ctrl #(.NCH(16), .SELW(4), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(ifc3.slave));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: ordered list of sel values seen while busy, one entry per cycle.
    function automatic void build_trace(input logic [15:0] m, input int settle, output logic [3:0] q[$]);
        q = {};
        if (m != 16'h0000) begin
            for (int c = 0; c < 16; c++) begin
                int hold;
                hold = m[c] ? settle + 1 : 1;
                for (int k = 0; k < hold; k++) q.push_back(4'(c));
            end
        end
    endfunction

    task automatic cmp_trace(input string tag, input logic [3:0] got[$], input logic [3:0] expq[$]);
        int bad;
        int n;
        bad = -1;
        chk({tag, " busy_cycles"}, 32'(got.size()), 32'(expq.size()));
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && got[i] !== expq[i]) bad = i;
        end
        chk({tag, " first_bad_sel_idx"}, 32'(bad), 32'(-1));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " d1 busy"}, 32'(ifc1.busy), 32'd0);
        chk({tag, " d1 done"}, 32'(ifc1.done), 32'd0);
        chk({tag, " d1 valid"}, 32'(ifc1.valid), 32'd0);
        chk({tag, " d1 sel"}, 32'(ifc1.sel), 32'd0);
        chk({tag, " d1 data"}, 32'(ifc1.data), 32'd0);
        chk({tag, " d3 busy"}, 32'(ifc3.busy), 32'd0);
        chk({tag, " d3 done"}, 32'(ifc3.done), 32'd0);
        chk({tag, " d3 valid"}, 32'(ifc3.valid), 32'd0);
        chk({tag, " d3 sel"}, 32'(ifc3.sel), 32'd0);
        chk({tag, " d3 data"}, 32'(ifc3.data), 32'd0);
    endtask

    // One scan on both instances; stray=1 pulses start while both are busy.
    task automatic run_scan(input string tag, input logic [15:0] m, input logic [15:0] x, input bit stray);
        logic [3:0] tr1[$];
        logic [3:0] tr3[$];
        logic [3:0] ex1[$];
        logic [3:0] ex3[$];
        int dcyc1 = 0, dcyc3 = 0, dcnt1 = 0, dcnt3 = 0;
        tr1 = {};
        tr3 = {};
        xval = x;
        mask = m;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                mask = 16'($urandom);
                if (m != 16'h0000) begin
                    chk({tag, " d1 valid_cleared"}, 32'(ifc1.valid), 32'd0);
                    chk({tag, " d3 valid_cleared"}, 32'(ifc3.valid), 32'd0);
                end
            end
            if (ifc1.busy) tr1.push_back(ifc1.sel);
            if (ifc3.busy) tr3.push_back(ifc3.sel);
            if (ifc1.done) begin
                dcnt1++;
                if (dcyc1 == 0) begin
                    dcyc1 = cyc;
                    chk({tag, " d1 done_busy"}, 32'(ifc1.busy), 32'd0);
                    chk({tag, " d1 done_sel"}, 32'(ifc1.sel), 32'd0);
                    chk({tag, " d1 done_valid"}, 32'(ifc1.valid), 32'd1);
                    chk({tag, " d1 done_data"}, 32'(ifc1.data), 32'(x & m));
                end
            end
            if (ifc3.done) begin
                dcnt3++;
                if (dcyc3 == 0) begin
                    dcyc3 = cyc;
                    chk({tag, " d3 done_busy"}, 32'(ifc3.busy), 32'd0);
                    chk({tag, " d3 done_sel"}, 32'(ifc3.sel), 32'd0);
                    chk({tag, " d3 done_valid"}, 32'(ifc3.valid), 32'd1);
                    chk({tag, " d3 done_data"}, 32'(ifc3.data), 32'(x & m));
                end
            end
            if (stray && ifc1.busy && ifc3.busy && (cyc % 3 == 0)) start = 1'b1;
            if (dcyc1 != 0 && dcyc3 != 0 && cyc > dcyc1 + 4 && cyc > dcyc3 + 4) break;
        end
        start = 1'b0;
        build_trace(m, 1, ex1);
        build_trace(m, 3, ex3);
        cmp_trace({tag, " d1"}, tr1, ex1);
        cmp_trace({tag, " d3"}, tr3, ex3);
        chk({tag, " d1 done_cycle"}, 32'(dcyc1), 32'(ex1.size() + 1));
        chk({tag, " d3 done_cycle"}, 32'(dcyc3), 32'(ex3.size() + 1));
        chk({tag, " d1 done_count"}, 32'(dcnt1), 32'd1);
        chk({tag, " d3 done_count"}, 32'(dcnt3), 32'd1);
        chk({tag, " d1 final_data"}, 32'(ifc1.data), 32'(x & m));
        chk({tag, " d3 final_data"}, 32'(ifc3.data), 32'(x & m));
        chk({tag, " d1 final_valid"}, 32'(ifc1.valid), 32'd1);
        chk({tag, " d3 final_valid"}, 32'(ifc3.valid), 32'd1);
    endtask

    initial begin
        int nb;
        int ndone;
        int nbusy;
        logic [15:0] rm;
        logic [15:0] rx;

        // Reset state.
        #1;
        chk_idle_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset mid-scan after 10 busy cycles.
        mask = 16'hFFFF;
        xval = 16'h5A5A;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 50 && nb < 10; i++) begin
            if (ifc1.busy) nb++;
            if (nb < 10) @(negedge clk);
        end
        chk("midscan busy_reached", 32'(nb), 32'd10);
        rst = 1'b1;
        #1;
        chk_idle_zero("midscan_rst");
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ifc1.done || ifc3.done) ndone++;
            if (ifc1.busy || ifc3.busy) nbusy++;
        end
        chk("post_rst done_seen", 32'(ndone), 32'd0);
        chk("post_rst busy_seen", 32'(nbusy), 32'd0);

        // Full scan, then X change without start, then rescan.
        run_scan("full_1234", 16'hFFFF, 16'h1234, 1'b0);
        xval = 16'hA5A5;
        repeat (6) @(negedge clk);
        chk("hold d1 data", 32'(ifc1.data), 32'h1234);
        chk("hold d3 data", 32'(ifc3.data), 32'h1234);
        chk("hold d1 valid", 32'(ifc1.valid), 32'd1);
        run_scan("full_a5a5", 16'hFFFF, 16'hA5A5, 1'b0);

        // Lower half enabled, upper half skipped.
        run_scan("low_half", 16'h00FF, 16'hFFFF, 1'b0);

        // Empty mask.
        run_scan("empty", 16'h0000, 16'hFFFF, 1'b0);

        // Ends only, stray starts during the scan.
        run_scan("ends_stray", 16'h8001, 16'h8001, 1'b1);

        // Randomized scans.
        for (int r = 0; r < 10; r++) begin
            rm = 16'($urandom);
            if (r % 3 == 1) rm = rm & 16'($urandom);
            rx = 16'($urandom);
            run_scan($sformatf("rand%0d", r), rm, rx, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
